// File: rtl/ram_arbiter_2ch_pkg.sv
// Shared widths, op codes and state encoding for the two-channel RAM controller.
package ram_ctrl_pkg;
  localparam int DATABIT      = 8;
  localparam int ADDRBIT      = 4;
  localparam int NOOFLOCATION = 16;

  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ  = 1'b0;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;
endpackage

// File: rtl/ram_arbiter_2ch_if.sv
// Client request/response bus plus RAM-side bus of the two-channel arbiter.
interface ram_arbiter_2ch_if;
  import ram_ctrl_pkg::*;

  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [1:0]           req_wr_rd;
  logic [2*ADDRBIT-1:0] req_add;
  logic [2*DATABIT-1:0] req_wdata;
  logic [1:0]           rsp_valid;
  logic [DATABIT-1:0]   rsp_rdata;
  logic                 mem_valid;
  logic                 mem_wr_rd;
  logic [ADDRBIT-1:0]   mem_add;
  logic [DATABIT-1:0]   mem_writedata;
  logic [DATABIT-1:0]   mem_readdata;
  logic                 mem_ready;

  modport slave (
    input  req_valid, req_wr_rd, req_add, req_wdata, mem_readdata, mem_ready,
    output req_ready, rsp_valid, rsp_rdata, mem_valid, mem_wr_rd, mem_add, mem_writedata
  );

  modport master (
    output req_valid, req_wr_rd, req_add, req_wdata, mem_readdata, mem_ready,
    input  req_ready, rsp_valid, rsp_rdata, mem_valid, mem_wr_rd, mem_add, mem_writedata
  );
endinterface

// File: rtl/ram_arbiter_2ch_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the channel not served last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic       gnt_valid,
  output logic       gnt_idx
);
  always_comb begin
    gnt_valid = |req;
    if (req == 2'b11) gnt_idx = ~rr_last;
    else              gnt_idx = req[1];
  end
endmodule

// File: rtl/ram_arbiter_2ch.sv
// Shares one single-port RAM between two clients: zero-clears it after reset, then serves
// one round-robin transaction at a time and pulses a completion to the owner.
//   state     | meaning
//   ST_CLEAR  | sweeping zeros into every RAM word
//   ST_IDLE   | waiting for clear_req or a client request
//   ST_ACCESS | latched transaction on the RAM bus until mem_ready
//   ST_RESP   | one-cycle completion to the owning channel
module ram_arbiter_2ch
  import ram_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear_req,
  output logic busy,
  output logic init_done,
  ram_arbiter_2ch_if.slave bus
);
  localparam logic [ADDRBIT-1:0] LAST_ADDR = ADDRBIT'(NOOFLOCATION - 1);

  state_t             state, state_nxt;
  logic [ADDRBIT-1:0] clr_cnt;
  logic               rr_last, own_q, op_q;
  logic [ADDRBIT-1:0] add_q;
  logic [DATABIT-1:0] wdata_q, rdata_q;
  logic               gnt_valid, gnt_idx, accept;

  logic [1:0]         req_ready, rsp_valid;
  logic [DATABIT-1:0] rsp_rdata, mem_writedata;
  logic               mem_valid, mem_wr_rd;
  logic [ADDRBIT-1:0] mem_add;

  rr_arb2 u_arb (
    .req       (bus.req_valid),
    .rr_last   (rr_last),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign accept = (state == ST_IDLE) && !clear_req && gnt_valid;
  assign busy   = (state != ST_IDLE);

  // Outputs are forced quiet while rst is held, even though the state already reads CLEAR.
  always_comb begin
    state_nxt     = state;
    mem_valid     = 1'b0;
    mem_wr_rd     = 1'b0;
    mem_add       = '0;
    mem_writedata = '0;
    req_ready     = 2'b00;
    rsp_valid     = 2'b00;
    rsp_rdata     = rdata_q;
    if (!rst) begin
      case (state)
        ST_CLEAR: begin
          mem_valid = 1'b1;
          mem_wr_rd = OP_WRITE;
          mem_add   = clr_cnt;
          if (bus.mem_ready && clr_cnt == LAST_ADDR) state_nxt = ST_IDLE;
        end
        ST_IDLE: begin
          if (clear_req) begin
            state_nxt = ST_CLEAR;
          end else if (gnt_valid) begin
            req_ready[gnt_idx] = 1'b1;
            state_nxt          = ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          mem_valid     = 1'b1;
          mem_wr_rd     = op_q;
          mem_add       = add_q;
          mem_writedata = wdata_q;
          if (bus.mem_ready) state_nxt = ST_RESP;
        end
        ST_RESP: begin
          rsp_valid[own_q] = 1'b1;
          if (op_q == OP_READ) rsp_rdata = bus.mem_readdata;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_CLEAR;
      clr_cnt   <= '0;
      rr_last   <= 1'b1;
      init_done <= 1'b0;
      own_q     <= 1'b0;
      op_q      <= OP_READ;
      add_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR && bus.mem_ready) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == LAST_ADDR) init_done <= 1'b1;
      end
      if (accept) begin
        own_q   <= gnt_idx;
        rr_last <= gnt_idx;
        op_q    <= bus.req_wr_rd[gnt_idx];
        add_q   <= gnt_idx ? bus.req_add[2*ADDRBIT-1:ADDRBIT] : bus.req_add[ADDRBIT-1:0];
        wdata_q <= gnt_idx ? bus.req_wdata[2*DATABIT-1:DATABIT] : bus.req_wdata[DATABIT-1:0];
      end
      if (state == ST_RESP && op_q == OP_READ) rdata_q <= bus.mem_readdata;
    end
  end

  assign bus.req_ready     = req_ready;
  assign bus.rsp_valid     = rsp_valid;
  assign bus.rsp_rdata     = rsp_rdata;
  assign bus.mem_valid     = mem_valid;
  assign bus.mem_wr_rd     = mem_wr_rd;
  assign bus.mem_add       = mem_add;
  assign bus.mem_writedata = mem_writedata;
endmodule

// File: tb/tb_ram_arbiter_2ch.sv
// Bench for ram_arbiter_2ch: behavioural RAM, response scoreboard, vector table and corner sequences.
module tb_ram_arbiter_2ch;
  import ram_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear_req = 1'b0;
  logic busy, init_done;
  int   cyc = 0;

  ram_arbiter_2ch_if bus ();

  ram_arbiter_2ch dut (
    .clk       (clk),
    .rst       (rst),
    .clear_req (clear_req),
    .busy      (busy),
    .init_done (init_done),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: garbage while in reset so the clear sweep is visible.
  logic [7:0] ram [16];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) ram[i] <= 8'(i * 7 + 3);
    end else if (bus.mem_valid && bus.mem_ready) begin
      if (bus.mem_wr_rd) ram[bus.mem_add] <= bus.mem_writedata;
      else               bus.mem_readdata <= ram[bus.mem_add];
    end
  end

  typedef struct {
    logic       rd;
    logic       ch;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic       ch;
    logic       wr;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    int         stall;
  } vec_t;

  exp_t       sb [$];
  vec_t       tbl [8];
  logic [7:0] ref_mem [16];
  logic [7:0] last_rd = 8'h00;
  logic       rr_model = 1'b1;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every completion must match the oldest accepted transaction.
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] want;
    if (!rst && bus.rsp_valid != 2'b00) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_owner", 32'(bus.rsp_valid), e.ch ? 32'd2 : 32'd1);
        if (e.rd) last_rd = e.data;
        want = last_rd;
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(want));
      end
    end
  end

  task automatic drive_req(input logic ch, input logic wr, input logic [3:0] addr, input logic [7:0] wd);
    bus.req_valid[ch] = 1'b1;
    bus.req_wr_rd[ch] = wr;
    if (ch) begin
      bus.req_add[7:4]    = addr;
      bus.req_wdata[15:8] = wd;
    end else begin
      bus.req_add[3:0]   = addr;
      bus.req_wdata[7:0] = wd;
    end
  endtask

  task automatic do_txn(input logic ch, input logic wr, input logic [3:0] addr,
                        input logic [7:0] wd, input logic [7:0] exp_rd, input int stall);
    int cnt;
    int t_acc;
    @(negedge clk);
    drive_req(ch, wr, addr, wd);
    cnt = 0;
    #1;
    while (!bus.req_ready[ch] && cnt < 30) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    chk("grant", 32'(bus.req_ready), ch ? 32'd2 : 32'd1);
    if (!bus.req_ready[ch]) begin
      bus.req_valid[ch] = 1'b0;
      return;
    end
    sb.push_back('{rd: !wr, ch: ch, data: exp_rd});
    if (wr) ref_mem[addr] = wd;
    rr_model = ch;
    @(posedge clk);
    #1;
    bus.req_valid[ch] = 1'b0;
    t_acc = cyc;
    if (stall > 0) begin
      bus.mem_ready = 1'b0;
      repeat (stall) @(posedge clk);
      #1;
      bus.mem_ready = 1'b1;
    end
    cnt = 0;
    @(negedge clk);
    while (!bus.rsp_valid[ch] && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("rsp_latency", 32'(cyc - t_acc), 32'(1 + stall));
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    while (sb.size() != 0 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  // Releases reset and follows the 16-word clear sweep while both clients request.
  task automatic release_and_sweep();
    @(negedge clk);
    bus.req_valid = 2'b11;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("clr_valid", 32'(bus.mem_valid), 32'd1);
      chk("clr_wr", 32'(bus.mem_wr_rd), 32'd1);
      chk("clr_add", 32'(bus.mem_add), 32'(i));
      chk("clr_wdata", 32'(bus.mem_writedata), 32'd0);
      chk("clr_ready_low", 32'(bus.req_ready), 32'd0);
      chk("clr_init_low", 32'(init_done), 32'd0);
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
    #1;
    chk("init_done_set", 32'(init_done), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk("ram_zero", 32'(ram[i]), 32'd0);
      ref_mem[i] = 8'h00;
    end
  endtask

  initial begin
    int cnt;
    int grants;
    logic g;
    bus.req_valid = 2'b00;
    bus.req_wr_rd = 2'b00;
    bus.req_add   = '0;
    bus.req_wdata = '0;
    bus.mem_ready = 1'b1;

    tbl[0] = '{ch: 1'b0, wr: 1'b1, addr: 4'd3,  wdata: 8'hA5, exp_rd: 8'h00, stall: 0};
    tbl[1] = '{ch: 1'b0, wr: 1'b0, addr: 4'd3,  wdata: 8'h00, exp_rd: 8'hA5, stall: 0};
    tbl[2] = '{ch: 1'b1, wr: 1'b1, addr: 4'd7,  wdata: 8'h3C, exp_rd: 8'h00, stall: 0};
    tbl[3] = '{ch: 1'b0, wr: 1'b0, addr: 4'd7,  wdata: 8'h00, exp_rd: 8'h3C, stall: 0};
    tbl[4] = '{ch: 1'b1, wr: 1'b0, addr: 4'd3,  wdata: 8'h00, exp_rd: 8'hA5, stall: 3};
    tbl[5] = '{ch: 1'b1, wr: 1'b1, addr: 4'd0,  wdata: 8'h5A, exp_rd: 8'h00, stall: 0};
    tbl[6] = '{ch: 1'b1, wr: 1'b0, addr: 4'd0,  wdata: 8'h00, exp_rd: 8'h5A, stall: 0};
    tbl[7] = '{ch: 1'b0, wr: 1'b0, addr: 4'd12, wdata: 8'h00, exp_rd: 8'h00, stall: 0};

    // Reset state with both clients requesting.
    bus.req_valid = 2'b11;
    repeat (3) @(negedge clk);
    chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    release_and_sweep();

    foreach (tbl[i]) do_txn(tbl[i].ch, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, tbl[i].stall);
    drain();

    // Both channels reading continuously: grants must alternate.
    @(negedge clk);
    drive_req(1'b0, 1'b0, 4'd3, 8'h00);
    drive_req(1'b1, 1'b0, 4'd7, 8'h00);
    grants = 0;
    cnt = 0;
    while (grants < 6 && cnt < 60) begin
      #1;
      if (bus.req_ready != 2'b00) begin
        g = ~rr_model;
        chk("ready_onehot", 32'($countones(bus.req_ready)), 32'd1);
        chk("rr_order", 32'(bus.req_ready), g ? 32'd2 : 32'd1);
        sb.push_back('{rd: 1'b1, ch: g, data: g ? ref_mem[7] : ref_mem[3]});
        rr_model = g;
        grants++;
      end
      if (grants == 6) begin
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
      end else begin
        @(negedge clk);
      end
      cnt++;
    end
    bus.req_valid = 2'b00;
    chk("rr_grants", 32'(grants), 32'd6);
    drain();

    // Re-clear from IDLE wins over a pending request.
    do_txn(1'b0, 1'b1, 4'd15, 8'hFF, 8'h00, 0);
    @(negedge clk);
    clear_req = 1'b1;
    drive_req(1'b0, 1'b0, 4'd15, 8'h00);
    #1;
    chk("clrreq_ready_low", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    bus.req_valid = 2'b00;
    chk("clrreq_busy", 32'(busy), 32'd1);
    chk("clrreq_add0", 32'(bus.mem_add), 32'd0);
    cnt = 0;
    while (busy && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("reclear_done", 32'(busy), 32'd0);
    chk("reclear_init", 32'(init_done), 32'd1);
    chk("reclear_ram15", 32'(ram[15]), 32'd0);
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    do_txn(1'b0, 1'b0, 4'd15, 8'h00, 8'h00, 0);

    // Reset during ACCESS of a write: dropped, no completion, full clear again.
    @(negedge clk);
    bus.mem_ready = 1'b0;
    drive_req(1'b1, 1'b1, 4'd5, 8'h77);
    #1;
    chk("rstmid_grant", 32'(bus.req_ready), 32'd2);
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("rstmid_access_add", 32'(bus.mem_add), 32'd5);
    chk("rstmid_access_wr", 32'(bus.mem_wr_rd), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rstmid_init_low", 32'(init_done), 32'd0);
    chk("rstmid_mem_valid", 32'(bus.mem_valid), 32'd0);
    last_rd  = 8'h00;
    rr_model = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstmid_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    bus.mem_ready = 1'b1;
    release_and_sweep();
    chk("rstmid_sb_empty", 32'(sb.size()), 32'd0);

    // After reset a tie goes to channel 0 first.
    @(negedge clk);
    drive_req(1'b0, 1'b0, 4'd3, 8'h00);
    drive_req(1'b1, 1'b0, 4'd7, 8'h00);
    #1;
    chk("post_rst_tie", 32'(bus.req_ready), 32'd1);
    if (bus.req_ready == 2'b01) sb.push_back('{rd: 1'b1, ch: 1'b0, data: ref_mem[3]});
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    drain();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end
endmodule
